seg_scan_encoder: RTL and testbench

SEG_SCAN_ENCODER -- requirements
Module: seg_scan_encoder

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg7_to_bcd.sv | 28 ++
 rtl/seg_scan_encoder.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan encoder.
package seg_pkg;

  localparam int unsigned NUM_DIG = 4;

  // Segment patterns, bit order {G,F,E,D,C,B,A}, active-high
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] BCD_INV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] code;
  } dig_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Seven-segment pattern to BCD lookup; unknown patterns map to BCD_INV with err set.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       err_o
);

  always_comb begin
    code_o = BCD_INV;
    err_o  = 1'b0;
    case (seg_i)
      SEG_0:   code_o = 4'd0;
      SEG_1:   code_o = 4'd1;
      SEG_2:   code_o = 4'd2;
      SEG_3:   code_o = 4'd3;
      SEG_4:   code_o = 4'd4;
      SEG_5:   code_o = 4'd5;
      SEG_6:   code_o = 4'd6;
      SEG_7:   code_o = 4'd7;
      SEG_8:   code_o = 4'd8;
      SEG_9:   code_o = 4'd9;
      default: err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_encoder.sv
// Recovers the four BCD digits shown on a multiplexed seven-segment display by
// debouncing each anode slot and assembling a frame once every digit is seen.
module seg_scan_encoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter bit          ACTIVE_LOW     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits_out,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam logic [7:0]  STB = 8'(STABLE_CYCLES);
  localparam logic [23:0] TMO = 24'(TIMEOUT_CYCLES);

  logic [6:0] seg_s1_q, seg_s2_q, seg_n;
  logic [3:0] an_s1_q, an_s2_q, an_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      an_s1_q  <= '0;
      an_s2_q  <= '0;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
    end
  end

  assign seg_n = ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
  assign an_n  = ACTIVE_LOW ? ~an_s2_q  : an_s2_q;

  // Exactly one anode lit is a sample; anything else is blanking
  logic       samp_vld;
  logic [1:0] samp_idx;

  always_comb begin
    samp_vld = (an_n != 4'd0) && ((an_n & (an_n - 4'd1)) == 4'd0);
    samp_idx = 2'd0;
    for (int i = 0; i < NUM_DIG; i++)
      if (an_n[i]) samp_idx = 2'(i);
  end

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [6:0] pat_q, pat_d;
  logic [7:0] cnt_q, cnt_d;
  logic       match, capture;

  assign match = samp_vld && (samp_idx == idx_q) && (seg_n == pat_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (samp_vld) begin
          idx_d   = samp_idx;
          pat_d   = seg_n;
          cnt_d   = 8'd1;
          state_d = (cnt_d >= STB) ? ST_HELD : ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (!samp_vld) begin
          state_d = ST_IDLE;
        end else if (match) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d >= STB) state_d = ST_HELD;
        end else begin
          idx_d   = samp_idx;
          pat_d   = seg_n;
          cnt_d   = 8'd1;
          state_d = (cnt_d >= STB) ? ST_HELD : ST_TRACK;
        end
      end
      ST_HELD: begin
        if (!samp_vld) begin
          state_d = ST_IDLE;
        end else if (samp_idx != idx_q) begin
          idx_d   = samp_idx;
          pat_d   = seg_n;
          cnt_d   = 8'd1;
          state_d = (cnt_d >= STB) ? ST_HELD : ST_TRACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture fires on every entry into HELD, including a HELD-to-HELD slot change
  always_comb begin
    capture = (state_d == ST_HELD) && ((state_q != ST_HELD) || (idx_d != idx_q));
  end

  logic [3:0] dec_code;
  logic       dec_err;

  seg7_to_bcd u_dec (
    .seg_i  (seg_n),
    .code_o (dec_code),
    .err_o  (dec_err)
  );

  logic [3:0] seen_q, seen_d;
  logic       frame_load, frame_valid_q;
  logic [23:0] tmo_q;

  assign frame_load = (seen_q == 4'hF);

  // A capture landing on the frame-load cycle survives the clear
  always_comb begin
    seen_d = frame_load ? 4'd0 : seen_q;
    if (capture) seen_d[samp_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q        <= '0;
      frame_valid_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      seen_q        <= seen_d;
      frame_valid_q <= frame_load;
      if (capture)           tmo_q <= '0;
      else if (tmo_q != TMO) tmo_q <= tmo_q + 24'd1;
    end
  end

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    dig_t wrk_q, out_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wrk_q <= '0;
        out_q <= '0;
      end else begin
        if (capture && samp_idx == 2'(g)) wrk_q <= '{err: dec_err, code: dec_code};
        if (frame_load)                   out_q <= wrk_q;
      end
    end

    assign digits_out[4*g +: 4] = out_q.code;
    assign digit_err[g]         = out_q.err;
  end

  assign frame_valid = frame_valid_q;
  assign stale       = (tmo_q == TMO);

endmodule

// File: tb/tb_seg_scan_encoder.sv
// Directed and randomized scans of the seven-segment encoder against a table-driven reference.
module tb_seg_scan_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  seg_scan_encoder #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits_out  (digits_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hold_bad = 0;
  logic [19:0] frames[$];
  logic [19:0] prev_out = '0;
  logic [3:0][6:0] p;

  localparam logic [6:0] PATS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Collects every frame pulse and notices output changes that happen without one
  always @(negedge clk) begin
    if (frame_valid) frames.push_back({digit_err, digits_out});
    else if (rst_n && ({digit_err, digits_out} !== prev_out)) hold_bad++;
    prev_out = {digit_err, digits_out};
  end

  function automatic logic [4:0] ref_dec(input logic [6:0] pat);
    for (int k = 0; k < 10; k++)
      if (PATS[k] == pat) return {1'b0, 4'(k)};
    return 5'h1F;
  endfunction

  function automatic logic [19:0] ref_frame(input logic [3:0][6:0] pp);
    logic [15:0] d;
    logic [3:0]  e;
    logic [4:0]  r;
    for (int i = 0; i < 4; i++) begin
      r = ref_dec(pp[i]);
      d[4*i +: 4] = r[3:0];
      e[i] = r[4];
    end
    return {e, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [6:0] pat, input int n);
    an_in  = ~(4'b0001 << idx);
    seg_in = ~pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    an_in  = 4'hF;
    seg_in = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [3:0][6:0] pp, input bit rnd);
    for (int i = 0; i < 4; i++) drive(i, pp[i], rnd ? int'($urandom_range(5, 12)) : 10);
    blank(8);
  endtask

  task automatic expect_frames(input string tag, input int n, input logic [19:0] exp);
    check({tag, "_count"}, frames.size(), n);
    if (n > 0 && frames.size() > 0) check({tag, "_value"}, frames[$], exp);
    frames.delete();
  endtask

  initial begin
    rst_n  = 1'b0;
    an_in  = 4'hF;
    seg_in = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_digits", digits_out, 16'h0);
    check("rst_err", digit_err, 4'h0);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_stale", stale, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_fv", frame_valid, 1'b0);
    blank(2);

    // Basic scan with exact capture/frame latency on the last digit
    drive(0, 7'h06, 10);
    drive(1, 7'h5B, 10);
    drive(2, 7'h4F, 10);
    an_in  = ~4'b1000;
    seg_in = ~7'h66;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      check($sformatf("lat_fv_%0d", n), frame_valid, (n == 7));
    end
    blank(8);
    expect_frames("basic", 1, {4'h0, 16'h4321});
    check("basic_out", digits_out, 16'h4321);

    // Unrecognised pattern on digit 2
    p = {7'h66, 7'h49, 7'h5B, 7'h06};
    scan4(p, 1'b0);
    expect_frames("bad_pat", 1, ref_frame(p));
    check("bad_pat_err", digit_err, 4'b0100);
    check("bad_pat_d2", digits_out[11:8], 4'hF);

    // Three-cycle glitch must not be captured
    drive(0, 7'h7F, 3);
    drive(0, 7'h06, 10);
    drive(1, 7'h5B, 10);
    drive(2, 7'h4F, 10);
    drive(3, 7'h66, 10);
    blank(8);
    expect_frames("glitch", 1, {4'h0, 16'h4321});

    // All anodes lit is blanking: scanning 1..3 afterwards must not complete a frame
    an_in  = 4'h0;
    seg_in = ~7'h3F;
    repeat (50) @(negedge clk);
    drive(1, 7'h7D, 10);
    drive(2, 7'h07, 10);
    drive(3, 7'h7F, 10);
    blank(8);
    expect_frames("allon", 0, 20'h0);
    drive(0, 7'h6F, 10);
    blank(8);
    expect_frames("allon_resume", 1, {4'h0, 16'h8769});

    // Randomized scans
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++)
        p[i] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : PATS[$urandom_range(0, 9)];
      scan4(p, 1'b1);
      expect_frames($sformatf("rand%0d", r), 1, ref_frame(p));
    end

    // Timeout: capture at edge 6, blanked until edge 160, next capture at edge 166
    an_in  = ~4'b0001;
    seg_in = ~7'h3F;
    for (int n = 1; n <= 170; n++) begin
      @(negedge clk);
      check($sformatf("stale_%0d", n), stale, (n >= 106 && n < 166));
      if (n == 6) begin
        an_in  = 4'hF;
        seg_in = 7'h7F;
      end
      if (n == 160) begin
        an_in  = ~4'b0010;
        seg_in = ~7'h06;
      end
    end
    blank(8);
    expect_frames("stale", 0, 20'h0);

    // Reset with a partial frame pending
    drive(0, 7'h6D, 10);
    drive(1, 7'h7D, 10);
    drive(2, 7'h07, 10);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_digits", digits_out, 16'h0);
    check("mid_rst_err", digit_err, 4'h0);
    check("mid_rst_fv", frame_valid, 1'b0);
    check("mid_rst_stale", stale, 1'b0);
    rst_n = 1'b1;
    blank(2);
    drive(3, 7'h7F, 10);
    blank(8);
    expect_frames("rst_partial", 0, 20'h0);
    drive(0, 7'h3F, 10);
    drive(1, 7'h06, 10);
    drive(2, 7'h5B, 10);
    blank(8);
    expect_frames("rst_new", 1, {4'h0, 16'h8210});

    check("hold_stable", hold_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
